// File: rtl/cmv_pkg.sv
// ----------------------------------------------------------------------------
// cmv_pkg
// Shared definitions for the CMV sensor-to-host pipe reader.
//   state_t          : reader FSM state encoding
//   CMV_FRAME_WORDS  : 32-bit words per 640x488 8-bit frame (4 pixels per word)
//   CMV_BLOCK_WORDS  : 32-bit words per host pipe block (1024 bytes)
// ----------------------------------------------------------------------------
package cmv_pkg;

    localparam int unsigned CMV_FRAME_WORDS = 78080;
    localparam int unsigned CMV_BLOCK_WORDS = 256;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_BLOCK = 2'd1,
        S_STREAM     = 2'd2,
        S_DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/cmv_pipe_reader.sv
// ----------------------------------------------------------------------------
// cmv_pipe_reader
// Streams one frame of 32-bit words from a sensor FIFO into a host block pipe.
// The host is only offered a block once the FIFO holds a full block; each host
// read strobe is forwarded as a FIFO read, and the FIFO's one-cycle read
// latency lines up with the pipe's one-cycle data latency.
//
// Parameters
//   FRAME_WORDS  words per frame, a multiple of BLOCK_WORDS
//   BLOCK_WORDS  words per host pipe block
//
// Ports
//   i_clk             single clock (FIFO read side and host pipe)
//   i_rst_n           asynchronous active-low reset
//   i_arm             pulse: stream one frame (accepted in S_IDLE only)
//   i_abort           pulse: drop the current frame, back to S_IDLE
//   i_fifo_data       FIFO read data, one cycle after o_fifo_read_en
//   i_fifo_prog_full  FIFO holds at least BLOCK_WORDS words
//   i_fifo_empty      FIFO empty flag
//   o_fifo_read_en    FIFO read enable
//   i_pipe_read       host pipe read strobe
//   o_pipe_ready      a full block is available to the host
//   o_pipe_data       data to the host pipe
//   o_busy            high outside S_IDLE
//   o_frame_done      one-cycle pulse after the last word of a frame
//   o_underrun        sticky: host read outside S_STREAM or from an empty FIFO
//   o_frame_count     completed frames, wraps modulo 2^16
//
// Build option
//   CMV_PIPE_TEST_PATTERN_EN  replaces o_pipe_data with a registered counting
//                             pattern (0, 1, 2, ... per frame); FIFO reads,
//                             flags and handshakes are unchanged.
// ----------------------------------------------------------------------------
module cmv_pipe_reader
    import cmv_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = CMV_FRAME_WORDS,
    parameter int unsigned BLOCK_WORDS = CMV_BLOCK_WORDS
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_arm,
    input  logic        i_abort,
    input  logic [31:0] i_fifo_data,
    input  logic        i_fifo_prog_full,
    input  logic        i_fifo_empty,
    output logic        o_fifo_read_en,
    input  logic        i_pipe_read,
    output logic        o_pipe_ready,
    output logic [31:0] o_pipe_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_underrun,
    output logic [15:0] o_frame_count
);

    localparam int unsigned FCW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned BCW = $clog2(BLOCK_WORDS + 1);

    // Count values just before the increment that completes a block / frame.
    localparam logic [BCW-1:0] BLOCK_LAST = BCW'(BLOCK_WORDS - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_WORDS - 1);

    state_t          state_q, state_d;
    logic [BCW-1:0]  block_cnt_q, block_cnt_d;
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            underrun_q, underrun_d;

    logic            arm_accept;
    logic            stream_rd;
    logic            block_last;
    logic            frame_last;
    logic            bad_read;

    assign arm_accept = (state_q == S_IDLE) && i_arm && !i_abort;
    assign stream_rd  = (state_q == S_STREAM) && i_pipe_read;
    assign block_last = (block_cnt_q == BLOCK_LAST);
    assign frame_last = (frame_cnt_q == FRAME_LAST);
    assign bad_read   = i_pipe_read && ((state_q != S_STREAM) || i_fifo_empty);

    // ------------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            block_cnt_q   <= '0;
            frame_cnt_q   <= '0;
            frame_count_q <= '0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            block_cnt_q   <= block_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_count_q <= frame_count_d;
            underrun_q    <= underrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       if (i_arm) state_d = S_WAIT_BLOCK;
                S_WAIT_BLOCK: if (i_fifo_prog_full) state_d = S_STREAM;
                S_STREAM: begin
                    if (i_pipe_read && block_last) begin
                        state_d = frame_last ? S_DONE : S_WAIT_BLOCK;
                    end
                end
                S_DONE:       state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Counter and flag next values
    // ------------------------------------------------------------------------
    always_comb begin
        block_cnt_d   = block_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_count_d = frame_count_q;
        underrun_d    = underrun_q;

        if (arm_accept) begin
            block_cnt_d = '0;
            frame_cnt_d = '0;
        end else if (stream_rd) begin
            // Counts advance on every host strobe, even one blocked by an
            // empty FIFO, so the block/frame framing stays aligned with the host.
            block_cnt_d = block_last ? '0 : block_cnt_q + 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        if ((state_q == S_DONE) && !i_abort) begin
            frame_count_d = frame_count_q + 16'd1;
        end

        // A bad read in the arming cycle is still reported.
        if (bad_read) begin
            underrun_d = 1'b1;
        end else if (arm_accept) begin
            underrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        o_fifo_read_en = stream_rd && !i_fifo_empty;
        o_pipe_ready   = (state_q == S_STREAM);
        o_busy         = (state_q != S_IDLE);
        o_frame_done   = (state_q == S_DONE) && !i_abort;
        o_underrun     = underrun_q;
        o_frame_count  = frame_count_q;
    end

`ifdef CMV_PIPE_TEST_PATTERN_EN
    // pat_cnt_q is the next value to hand out; pat_data_q presents it one
    // cycle after the strobe, matching the FIFO's read latency.
    logic [31:0] pat_cnt_q;
    logic [31:0] pat_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pat_cnt_q  <= '0;
            pat_data_q <= '0;
        end else if (arm_accept) begin
            pat_cnt_q  <= '0;
            pat_data_q <= '0;
        end else if (stream_rd) begin
            pat_cnt_q  <= pat_cnt_q + 32'd1;
            pat_data_q <= pat_cnt_q;
        end
    end

    assign o_pipe_data = pat_data_q;
`else
    assign o_pipe_data = i_fifo_data;
`endif

endmodule
